// File: rtl/matrix_mac_engine.sv
// Pipelined multiply / crossbar-route / adder-tree reduce engine with multi-beat
// accumulation, fixed-point rescale and saturation. Four stages, valid/ready flow.

module matrix_mac_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    adv_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  output logic [2*DATA_WIDTH-1:0] p_o
);
  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] ae, be, prod;
  logic        [PW-1:0] p_q;

  always_comb begin
    ae   = PW'($signed(a_i));
    be   = PW'($signed(b_i));
    prod = ae * be;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)        p_q <= '0;
    else if (adv_i) begin
      if (en_i)      p_q <= prod;
      else           p_q <= '0;
    end
  end

  assign p_o = p_q;
endmodule

module matrix_mac_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int FRAC_BITS   = 0,
  parameter int MAX_BEATS   = 16,
  parameter int SEL_WIDTH   = $clog2(KERNEL_SIZE*KERNEL_SIZE),
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE) + $clog2(MAX_BEATS)
) (
  input  logic                                              Clk,
  input  logic                                              Rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     multiplier_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     multiplicand_in,
  input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]                lane_en,
  input  logic                                              direct,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*SEL_WIDTH-1:0]      route_sel,
  input  logic                                              last,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [DATA_WIDTH-1:0]                             out_data,
  output logic                                              out_saturated,
  output logic [$clog2(MAX_BEATS+1)-1:0]                    out_beats
);
  localparam int LANES  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int CW     = $clog2(MAX_BEATS + 1);
  localparam int STAGES = 3;
  localparam int LV     = $clog2(LANES);
  localparam int TN     = 1 << LV;
  localparam logic [SEL_WIDTH:0] LANES_W = (SEL_WIDTH+1)'(LANES);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    $signed({{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

  typedef struct packed {
    logic                              direct;
    logic [LANES-1:0][SEL_WIDTH-1:0]   sel;
    logic                              last;
  } ctl_t;

  logic                         adv, accept;
  logic [STAGES:1]              vld_pipe;
  logic [LANES-1:0][DATA_WIDTH-1:0] a_w, b_w;
  logic [LANES-1:0][PW-1:0]     p1;
  ctl_t                         ctl1_q;
  logic [LANES-1:0][PW-1:0]     x_d, x_q;
  logic                         last2_q, last3_q;
  logic signed [ACC_WIDTH-1:0]  sum_d, sum_q, acc_q, acc_next, r;
  logic [CW-1:0]                cnt_q, cnt_next;
  logic                         out_valid_q, out_sat_q, sat_d;
  logic [DATA_WIDTH-1:0]        out_data_q, data_d;
  logic [CW-1:0]                out_beats_q;

  // Whole pipeline freezes only when a finished result is blocked downstream.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv && Rst;
  assign accept   = in_valid && in_ready;

  assign a_w = multiplier_in;
  assign b_w = multiplicand_in;

  // S1: per-lane signed multiply with enable mask
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    matrix_mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .Clk   (Clk),
      .Rst   (Rst),
      .adv_i (adv),
      .en_i  (lane_en[g]),
      .a_i   (a_w[g]),
      .b_i   (b_w[g]),
      .p_o   (p1[g])
    );
  end

  // S2: crossbar; out-of-range indices read as zero
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      x_d[j] = '0;
      if (ctl1_q.direct)                         x_d[j] = p1[j];
      else if ({1'b0, ctl1_q.sel[j]} < LANES_W)  x_d[j] = p1[ctl1_q.sel[j]];
    end
  end

  // S3: balanced tree, padded with zero leaves up to a power of two
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    logic signed [ACC_WIDTH-1:0] n [TN>>l];
    for (genvar i = 0; i < (TN >> l); i++) begin : g_n
      if (l == 0) begin : g_leaf
        if (i < LANES) begin : g_in
          assign n[i] = ACC_WIDTH'($signed(x_q[i]));
        end else begin : g_pad
          assign n[i] = '0;
        end
      end else begin : g_add
        assign n[i] = g_lvl[l-1].n[2*i] + g_lvl[l-1].n[2*i+1];
      end
    end
  end
  assign sum_d = g_lvl[LV].n[0];

  // S4: accumulate, rescale, clip
  always_comb begin
    acc_next = acc_q + sum_q;
    cnt_next = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + 1'b1;
    r        = acc_next >>> FRAC_BITS;
    data_d   = r[DATA_WIDTH-1:0];
    sat_d    = 1'b0;
    if (r > SAT_MAX) begin
      data_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      sat_d  = 1'b1;
    end else if (r < SAT_MIN) begin
      data_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_pipe    <= '0;
      ctl1_q      <= '0;
      x_q         <= '0;
      last2_q     <= 1'b0;
      sum_q       <= '0;
      last3_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
    end else if (adv) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], accept};
      ctl1_q      <= {direct, route_sel, last};
      x_q         <= x_d;
      last2_q     <= ctl1_q.last;
      sum_q       <= sum_d;
      last3_q     <= last2_q;
      out_valid_q <= vld_pipe[STAGES] && last3_q;
      if (vld_pipe[STAGES]) begin
        if (last3_q) begin
          out_data_q  <= data_d;
          out_sat_q   <= sat_d;
          out_beats_q <= cnt_next;
          acc_q       <= '0;
          cnt_q       <= '0;
        end else begin
          acc_q       <= acc_next;
          cnt_q       <= cnt_next;
        end
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_saturated = out_sat_q;
  assign out_beats     = out_beats_q;
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed bench for matrix_mac_engine: single-beat vector table, then
// accumulation, beat-count clip, backpressure and mid-group reset sequences.

module tb_matrix_mac_engine;
  localparam int DW = 16;
  localparam int KS = 3;
  localparam int L  = KS * KS;
  localparam int SW = 4;
  localparam int CW = 5;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  logic                    in_valid, direct, last, out_ready;
  logic [L-1:0][DW-1:0]    a_in, b_in;
  logic [L-1:0]            lane_en;
  logic [L-1:0][SW-1:0]    route_sel;
  logic                    in_ready, out_valid, out_sat;
  logic [DW-1:0]           out_data;
  logic [CW-1:0]           out_beats;
  logic                    in_ready2, out_valid2, out_sat2;
  logic [DW-1:0]           out_data2;
  logic [CW-1:0]           out_beats2;

  matrix_mac_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .FRAC_BITS(0)) u_dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .multiplier_in(a_in), .multiplicand_in(b_in), .lane_en(lane_en),
    .direct(direct), .route_sel(route_sel), .last(last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_saturated(out_sat), .out_beats(out_beats)
  );

  matrix_mac_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .FRAC_BITS(2)) u_dut2 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready2),
    .multiplier_in(a_in), .multiplicand_in(b_in), .lane_en(lane_en),
    .direct(direct), .route_sel(route_sel), .last(last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_saturated(out_sat2), .out_beats(out_beats2)
  );

  typedef struct {
    string                 name;
    logic [L-1:0][DW-1:0]  a, b;
    logic [L-1:0]          en;
    logic                  dir;
    logic [L-1:0][SW-1:0]  sel;
    int                    exp0;
    bit                    sat0;
    int                    exp2;
    bit                    sat2;
  } vec_t;

  vec_t tbl [9];
  int   nchk = 0, nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit lst);
    a_in      = v.a;
    b_in      = v.b;
    lane_en   = v.en;
    direct    = v.dir;
    route_sel = v.sel;
    last      = lst;
    in_valid  = 1'b1;
  endtask

  task automatic beat(input vec_t v, input bit lst);
    @(negedge Clk);
    drive(v, lst);
    @(posedge Clk);
  endtask

  function automatic vec_t mk_sum(input int k);
    vec_t v;
    v = tbl[0];
    v.en = 9'h001;
    v.a[0] = 16'(k);
    v.b[0] = 16'd1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    int   nv, rx, sent, nstall;
    longint d, bts, d2;

    for (int k = 0; k < 9; k++) begin
      tbl[k].en = '1; tbl[k].dir = 1'b1; tbl[k].sel = '0;
      tbl[k].sat0 = 1'b0; tbl[k].sat2 = 1'b0;
      for (int n = 0; n < L; n++) begin tbl[k].a[n] = 16'd2; tbl[k].b[n] = 16'd3; end
    end
    tbl[0].name = "direct54"; tbl[0].exp0 = 54; tbl[0].exp2 = 13;

    tbl[1].name = "fanout"; tbl[1].dir = 1'b0;
    for (int n = 0; n < L; n++) begin tbl[1].a[n] = 16'd1; tbl[1].b[n] = 16'd1; end
    tbl[1].a[0] = 16'd5; tbl[1].b[0] = 16'd7; tbl[1].exp0 = 315; tbl[1].exp2 = 78;

    tbl[2] = tbl[1]; tbl[2].name = "mask"; tbl[2].dir = 1'b1; tbl[2].en = 9'h001;
    tbl[2].exp0 = 35; tbl[2].exp2 = 8;

    tbl[3].name = "idx9"; tbl[3].dir = 1'b0;
    for (int j = 0; j < L; j++) tbl[3].sel[j] = 4'(j);
    tbl[3].sel[0] = 4'd9; tbl[3].exp0 = 48; tbl[3].exp2 = 12;

    tbl[4].name = "satpos";
    for (int n = 0; n < L; n++) begin tbl[4].a[n] = 16'h7FFF; tbl[4].b[n] = 16'h7FFF; end
    tbl[4].exp0 = 32767; tbl[4].sat0 = 1'b1; tbl[4].exp2 = 32767; tbl[4].sat2 = 1'b1;

    tbl[5].name = "satneg";
    for (int n = 0; n < L; n++) begin tbl[5].a[n] = 16'h8000; tbl[5].b[n] = 16'h7FFF; end
    tbl[5].exp0 = -32768; tbl[5].sat0 = 1'b1; tbl[5].exp2 = -32768; tbl[5].sat2 = 1'b1;

    tbl[6].name = "signed";
    for (int n = 0; n < L; n++) begin tbl[6].a[n] = 16'(n - 4); tbl[6].b[n] = 16'(n); end
    tbl[6].exp0 = 60; tbl[6].exp2 = 15;

    tbl[7].name = "negsum"; tbl[7].en = 9'h0FF;
    for (int n = 0; n < L; n++) begin tbl[7].a[n] = 16'hFFFF; tbl[7].b[n] = 16'd100; end
    tbl[7].exp0 = -800; tbl[7].exp2 = -200;

    tbl[8].name = "revroute"; tbl[8].dir = 1'b0; tbl[8].en = 9'h0FF;
    for (int n = 0; n < L; n++) begin
      tbl[8].a[n] = 16'(n); tbl[8].b[n] = 16'd1; tbl[8].sel[n] = 4'(8 - n);
    end
    tbl[8].exp0 = 28; tbl[8].exp2 = 7;

    // reset state
    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; last = 1'b0; direct = 1'b0;
    a_in = '0; b_in = '0; lane_en = '0; route_sel = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_beats", out_beats, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;

    // single-beat vector table
    for (int k = 0; k < 9; k++) begin
      beat(tbl[k], 1'b1);
      @(negedge Clk) in_valid = 1'b0;
      repeat (2) @(posedge Clk);
      #1 chk({tbl[k].name, "_early"}, out_valid, 0);
      @(posedge Clk);
      #1;
      chk({tbl[k].name, "_valid"}, out_valid, 1);
      chk({tbl[k].name, "_data"}, $signed(out_data), tbl[k].exp0);
      chk({tbl[k].name, "_sat"}, out_sat, tbl[k].sat0);
      chk({tbl[k].name, "_beats"}, out_beats, 1);
      chk({tbl[k].name, "_data_f2"}, $signed(out_data2), tbl[k].exp2);
      chk({tbl[k].name, "_sat_f2"}, out_sat2, tbl[k].sat2);
    end

    // three-beat accumulation
    beat(tbl[0], 1'b0);
    beat(tbl[0], 1'b0);
    beat(tbl[0], 1'b1);
    @(negedge Clk) in_valid = 1'b0;
    nv = 0; d = 0; bts = 0; d2 = 0;
    repeat (8) begin
      @(negedge Clk);
      if (out_valid) begin
        nv++; d = $signed(out_data); bts = out_beats; d2 = $signed(out_data2);
      end
    end
    chk("acc_count", nv, 1);
    chk("acc_data", d, 162);
    chk("acc_beats", bts, 3);
    chk("acc_data_f2", d2, 40);

    // beat counter clips at MAX_BEATS
    z = tbl[0]; z.en = '0;
    repeat (16) beat(z, 1'b0);
    beat(z, 1'b1);
    @(negedge Clk) in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("maxbeats_valid", out_valid, 1);
    chk("maxbeats_beats", out_beats, 16);
    chk("maxbeats_data", $signed(out_data), 0);
    repeat (2) @(posedge Clk);

    // backpressure with continuous single-beat groups
    rx = 0; sent = 0; nstall = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge Clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) drive(mk_sum(sent + 1), 1'b1);
      else          in_valid = 1'b0;
      #1;
      if (out_valid) begin
        chk("bp_order", $signed(out_data), rx + 1);
        if (out_ready) rx++;
        else begin
          nstall++;
          chk("bp_in_ready", in_ready, 0);
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_received", rx, 8);
    chk("bp_sent", sent, 8);
    chk("bp_stalls", nstall, 5);

    // asynchronous reset in the middle of a group
    repeat (2) @(posedge Clk);
    beat(tbl[0], 1'b0);
    beat(tbl[0], 1'b0);
    @(negedge Clk) in_valid = 1'b0;
    repeat (5) @(posedge Clk);
    #3 Rst = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_sat", out_sat, 0);
    chk("mrst_beats", out_beats, 0);
    chk("mrst_in_ready", in_ready, 0);
    @(negedge Clk) Rst = 1'b1;
    beat(tbl[0], 1'b1);
    @(negedge Clk) in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("postrst_valid", out_valid, 1);
    chk("postrst_data", $signed(out_data), 54);
    chk("postrst_beats", out_beats, 1);
    chk("postrst_data_f2", $signed(out_data2), 13);
    repeat (2) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
